struct_frame_packer: RTL and testbench
======================================

# struct_frame_packer

- Assembles a byte stream into one packed record: 6-element packed byte array `a` plus 16-bit field `b`, 64 bits total.
- Sits directly upstream of the stages that consume the packed record and index its fields by element and part-select.
- Writes each accepted byte into its lane by struct element select and zero-fills lanes a short frame leaves unwritten.
- Hands completed records downstream through a valid/ready output slot, with one frame of internal buffering.

## Interface
Parameters:
- none; geometry fixed by package constants (A_ELEMS = 6, FRAME_BYTES = 8)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input byte valid
- in_ready  out  1  block accepts byte when in_valid && in_ready
- in_data  in  8  input byte
- in_last  in  1  marks final byte of frame
- out_valid  out  1  out_frame/out_len/out_ovf valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_frame  out  64  frame_t: {a[5],…,a[0], b[15:0]}, a[5] at MSB
- out_len  out  4  bytes stored, 1..8
- out_ovf  out  1  frame carried more than 8 bytes

## Operation
- Lane map by byte index k: k = 0..5 write acc.a[k]; k = 6 writes acc.b[7:0]; k = 7 writes acc.b[15:8].
- Accumulator is cleared to '0 at reset and at every frame hand-off. Lanes not written by a short frame stay zero.
- States:
  - FILL: count 0..7; each accepted byte writes its lane and increments count.
  - DISCARD: entered when byte 8 is accepted without in_last. Further bytes are accepted and dropped, ovf is set, and the state runs until in_last.
  - HOLD: frame complete, output slot busy.
- Completion happens when in_last is accepted, in FILL or DISCARD.
  - len = min(bytes accepted, 8); ovf = 1 if more than 8 bytes.
  - If the slot is free or draining that cycle (!out_valid || out_ready): frame, len and ovf load into the output slot; accumulator clears; state goes to FILL, count 0.
  - Otherwise: state goes to HOLD.
- HOLD: in_ready = 0. On the first cycle with !out_valid || out_ready, the frame transfers to the slot, then the accumulator clears and the state goes to FILL.
- Output slot holds its value stable while out_valid && !out_ready.
- out_valid drops after acceptance unless a new frame loads in the same cycle.
- in_ready is registered: 1 in FILL/DISCARD, 0 in HOLD.
- in_last on a single-byte frame is legal: len = 1.

## Timing
- Reset values: out_valid 0, out_frame 0, out_len 0, out_ovf 0, in_ready 1; state FILL, count 0, accumulator 0.
- Latency: out_valid rises the cycle after in_last is accepted when the slot is free.
- Stalled path: out_valid rises the cycle after the out_ready handshake frees the slot. in_ready reasserts in that same cycle, giving one bubble.
- Throughput: back-to-back frames run at one byte per cycle when downstream never stalls.
- Simultaneous out handshake and completion: the new frame replaces the old in the same edge, with no gap in out_valid.
- Reset mid-frame discards the partial frame and any held or output frame.

## Structure
- Package struct_frame_pkg holds:
  - A_ELEMS, FRAME_BYTES
  - typedef frame_t: packed struct {bit [A_ELEMS-1:0][7:0] a; bit [15:0] b;}
  - state enum {FILL, DISCARD, HOLD}
- Lane writes must use field and element selects on the frame_t accumulator, not flat bit offsets.
- One sub-module: frame_out_slot, the valid/ready holding register for {frame_t, len, ovf}.

## Test plan
- Bytes 11,22,33,44,55,66,77,88 with last on 88 -> out_frame 64'h6655_4433_2211_8877, len 8, ovf 0.
- Bytes AA,BB,CC with last on CC -> out_frame 64'h0000_00CC_BBAA_0000, len 3.
- Bytes 01..0A with last on 0A -> out_frame 64'h0605_0403_0201_0807, len 8, ovf 1; in_ready stays 1 throughout.
- out_ready = 0; frame A (1 byte, 5A) then frame B (1 byte, C3):
  - in_ready falls after B's last.
  - After out_ready rises: A (64'h0000_0000_005A_0000) then B (…00C3_0000) emitted in order.
  - Both frames out_len 1, out_ovf 0.
- rst after 4 bytes of a frame, then byte 5A with last -> 64'h0000_0000_005A_0000, len 1; no stale lanes.
- Single-byte frames every cycle with out_ready = 1 -> out_valid high continuously, each frame correct.

Source files
------------

// File: rtl/struct_frame_packer_pkg.sv
// Shared geometry and types for the byte-to-record frame packer.
//   A_ELEMS     : number of byte elements in the packed array field a
//   FRAME_BYTES : bytes held by one record (A_ELEMS bytes of a + 2 bytes of b)
//   frame_t     : packed record {a[5..0], b[15:0]}, a[5] at the MSB
//   state_t     : packer control states
package struct_frame_pkg;

  localparam int A_ELEMS     = 6;
  localparam int FRAME_BYTES = 8;

  typedef struct packed {
    bit [A_ELEMS-1:0][7:0] a;
    bit [15:0]             b;
  } frame_t;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/struct_frame_packer_out_slot.sv
// Valid/ready holding register for one completed record.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   load                   : capture load_frame/load_len/load_ovf this cycle
//   load_frame/len/ovf     : record presented by the packer
//   out_ready              : downstream accepts when out_valid && out_ready
//   out_valid/frame/len/ovf: registered output slot
// The packer only asserts load when the slot is empty or draining, so a
// load always wins over a drain and keeps out_valid high without a gap.
module frame_out_slot
  import struct_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  frame_t     load_frame,
  input  logic [3:0] load_len,
  input  logic       load_ovf,
  input  logic       out_ready,
  output logic       out_valid,
  output frame_t     out_frame,
  output logic [3:0] out_len,
  output logic       out_ovf
);

  // Slot register: load a new record, drain on handshake, else hold stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_frame <= frame_t'(64'd0);
      out_len   <= 4'd0;
      out_ovf   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_frame <= load_frame;
      out_len   <= load_len;
      out_ovf   <= load_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/struct_frame_packer.sv
// Packs a byte stream into one frame_t record per frame.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input byte handshake (in_ready is registered)
//   in_data, in_last    : input byte and end-of-frame marker
//   out_valid/out_ready : output record handshake
//   out_frame           : packed record {a[5..0], b[15:0]}
//   out_len             : bytes stored, 1..8
//   out_ovf             : frame carried more than 8 bytes
// Byte k goes to a[k] for k < 6, then b[7:0], then b[15:8]. Unwritten lanes
// stay zero because the accumulator is cleared at every hand-off.
module struct_frame_packer
  import struct_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_frame,
  output logic [3:0]  out_len,
  output logic        out_ovf
);

  state_t     state_r, state_s;
  logic [3:0] count_r, count_s;
  frame_t     acc_r, acc_s;
  frame_t     written_s;
  logic       ovf_r, ovf_s;
  logic       in_ready_r, in_ready_s;
  logic       accept_s;
  logic       slot_free_s;
  logic       load_s;
  frame_t     load_frame_s;
  logic [3:0] load_len_s;
  logic       load_ovf_s;
  frame_t     slot_frame_s;

  assign accept_s    = in_valid && in_ready_r;
  assign slot_free_s = !out_valid || out_ready;
  assign in_ready    = in_ready_r;
  assign out_frame   = slot_frame_s;

  // Accumulator with the current byte dropped into its lane.
  always_comb begin
    written_s = acc_r;
    case (count_r[2:0])
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5: written_s.a[count_r[2:0]] = in_data;
      3'd6:    written_s.b[7:0]  = in_data;
      3'd7:    written_s.b[15:8] = in_data;
      default: written_s = acc_r;
    endcase
  end

  // Next-state, accumulator update and slot load decision.
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    acc_s        = acc_r;
    ovf_s        = ovf_r;
    load_s       = 1'b0;
    load_frame_s = acc_r;
    load_len_s   = count_r;
    load_ovf_s   = ovf_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          load_frame_s = written_s;
          load_len_s   = count_r + 4'd1;
          load_ovf_s   = 1'b0;
          if (in_last) begin
            if (slot_free_s) begin
              load_s  = 1'b1;
              acc_s   = frame_t'(64'd0);
              count_s = 4'd0;
              ovf_s   = 1'b0;
              state_s = FILL;
            end else begin
              // Keep the finished record and its length until the slot frees.
              acc_s   = written_s;
              count_s = count_r + 4'd1;
              ovf_s   = 1'b0;
              state_s = HOLD;
            end
          end else if (count_r == 4'd7) begin
            // Eighth byte without last: the frame must be longer than 8.
            acc_s   = written_s;
            count_s = 4'd8;
            ovf_s   = 1'b1;
            state_s = DISCARD;
          end else begin
            acc_s   = written_s;
            count_s = count_r + 4'd1;
          end
        end else begin
          state_s = FILL;
        end
      end
      DISCARD: begin
        if (accept_s && in_last) begin
          if (slot_free_s) begin
            load_s  = 1'b1;
            acc_s   = frame_t'(64'd0);
            count_s = 4'd0;
            ovf_s   = 1'b0;
            state_s = FILL;
          end else begin
            state_s = HOLD;
          end
        end else begin
          state_s = DISCARD;
        end
      end
      HOLD: begin
        if (slot_free_s) begin
          load_s  = 1'b1;
          acc_s   = frame_t'(64'd0);
          count_s = 4'd0;
          ovf_s   = 1'b0;
          state_s = FILL;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        acc_s   = frame_t'(64'd0);
        count_s = 4'd0;
        ovf_s   = 1'b0;
        state_s = FILL;
      end
    endcase
  end

  // in_ready follows the next state so it is valid straight from a flop.
  always_comb begin
    case (state_s)
      HOLD:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b1;
    endcase
  end

  // Control and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      count_r    <= 4'd0;
      acc_r      <= frame_t'(64'd0);
      ovf_r      <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      acc_r      <= acc_s;
      ovf_r      <= ovf_s;
      in_ready_r <= in_ready_s;
    end
  end

  frame_out_slot u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_frame (load_frame_s),
    .load_len   (load_len_s),
    .load_ovf   (load_ovf_s),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_frame  (slot_frame_s),
    .out_len    (out_len),
    .out_ovf    (out_ovf)
  );

endmodule

// File: tb/tb_struct_frame_packer.sv
// Scoreboard bench for struct_frame_packer: stimulus pushes expected records,
// a negedge monitor pops and compares on every output handshake.
module tb_struct_frame_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_frame;
  logic [3:0]  out_len;
  logic        out_ovf;

  typedef struct packed {
    logic [63:0] frame;
    logic [3:0]  len;
    logic        ovf;
  } exp_t;
  typedef logic [7:0] byte_q_t[$];

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready_en = 1'b0;
  bit   track_ready = 1'b0;
  int   in_ready_low = 0;
  bit   track_valid = 1'b0;
  int   out_valid_low = 0;

  struct_frame_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_frame (out_frame),
    .out_len   (out_len),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: bytes laid out by index, first six into a, next two into b.
  function automatic exp_t model(input byte_q_t q);
    logic [7:0] lanes [8];
    exp_t e;
    for (int i = 0; i < 8; i++) lanes[i] = 8'h00;
    for (int i = 0; i < q.size() && i < 8; i++) lanes[i] = q[i];
    e.frame = {lanes[5], lanes[4], lanes[3], lanes[2], lanes[1], lanes[0], lanes[7], lanes[6]};
    e.len   = (q.size() > 8) ? 4'd8 : 4'(q.size());
    e.ovf   = (q.size() > 8);
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] f, input logic [3:0] l, input logic o);
    exp_t e;
    e.frame = f; e.len = l; e.ovf = o;
    return e;
  endfunction

  // Monitor: compare every accepted output record against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", out_frame);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_frame", out_frame, mon_e.frame);
        check("out_len", 64'(out_len), 64'(mon_e.len));
        check("out_ovf", 64'(out_ovf), 64'(mon_e.ovf));
      end
    end
    if (track_ready && !in_ready) in_ready_low++;
    if (track_valid && !out_valid) out_valid_low++;
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  // Drive one frame's bytes; called and returning at posedge+1.
  task automatic send_bytes(input byte_q_t q, input bit with_last);
    for (int i = 0; i < q.size(); i++) begin
      int waits;
      bit acc;
      waits = 0;
      in_valid = 1'b1;
      in_data  = q[i];
      in_last  = with_last && (i == q.size() - 1);
      do begin
        acc = in_ready;
        @(posedge clk);
        #1;
        waits++;
      end while (!acc && waits < 300);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout actual=0 expected=1");
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    byte_q_t q;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_frame", out_frame, 64'd0);
    check("rst_out_len", 64'(out_len), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full 8-byte frame.
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    exp_q.push_back(mk(64'h6655_4433_2211_8877, 4'd8, 1'b0));
    send_bytes(q, 1'b1);
    // Short frame, zero-filled lanes.
    q = '{8'hAA, 8'hBB, 8'hCC};
    exp_q.push_back(mk(64'h0000_00CC_BBAA_0000, 4'd3, 1'b0));
    send_bytes(q, 1'b1);
    wait_drain();

    // Overlong frame: in_ready must stay high throughout.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    exp_q.push_back(mk(64'h0605_0403_0201_0807, 4'd8, 1'b1));
    track_ready = 1'b1;
    send_bytes(q, 1'b1);
    track_ready = 1'b0;
    check("ovf_in_ready_low_cycles", 64'(in_ready_low), 64'd0);
    wait_drain();

    // Stall: A in slot, B held, in_ready drops.
    out_ready = 1'b0;
    exp_q.push_back(mk(64'h0000_0000_005A_0000, 4'd1, 1'b0));
    exp_q.push_back(mk(64'h0000_0000_00C3_0000, 4'd1, 1'b0));
    q = '{8'h5A};
    send_bytes(q, 1'b1);
    q = '{8'hC3};
    send_bytes(q, 1'b1);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_out_valid", 64'(out_valid), 64'd1);
    check("hold_frame_stable", out_frame, 64'h0000_0000_005A_0000);
    out_ready = 1'b1;
    wait_drain();
    check("hold_release_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-frame, then a single byte frame.
    q = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    send_bytes(q, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(mk(64'h0000_0000_005A_0000, 4'd1, 1'b0));
    q = '{8'h5A};
    send_bytes(q, 1'b1);
    wait_drain();

    // Back-to-back single-byte frames: out_valid must stay high.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      q = '{8'($urandom)};
      exp_q.push_back(model(q));
      send_bytes(q, 1'b1);
      if (i == 0) track_valid = 1'b1;
    end
    track_valid = 1'b0;
    check("continuous_out_valid_gaps", 64'(out_valid_low), 64'd0);
    wait_drain();

    // Randomized frames with random backpressure and input gaps.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int n;
      n = $urandom_range(1, 11);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      e = model(q);
      exp_q.push_back(e);
      send_bytes(q, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
